// File: rtl/vga_game_pkg.sv
// Shared definitions for the VGA block game: screen geometry, scheduler
// state encoding and the move-direction type.
package vga_game_pkg;

  // 800x600 active area (40 MHz pixel clock timing); vga_ctrl uses these too.
  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_FRAME,
    S_STEP
  } sched_state_t;

  // bit0 = +x, bit1 = +y; both set is a diagonal move.
  typedef logic [1:0] dir_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with simultaneous push/pop and registered
// full/empty flags. Read data is show-ahead (head entry always visible).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Accept/consume decisions and next-state pointers/flags.
  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/move_cmd_sched.sv
// Frame-synchronous block movement scheduler. Key pulses are queued as move
// commands and each is animated PIX_PER_FRAME pixels per frame until STEP
// pixels have elapsed. Owns the block position registers.
// Build option: MOVE_SCHED_CLAMP_EN saturates the position at the screen edge
// instead of wrapping it to 0.
module move_cmd_sched #(
  parameter int unsigned H_ACTIVE      = vga_game_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE      = vga_game_pkg::V_ACTIVE,
  parameter int unsigned BLK_W         = 40,
  parameter int unsigned BLK_H         = 40,
  parameter int unsigned STEP          = 40,
  parameter int unsigned PIX_PER_FRAME = 4,
  parameter int unsigned INIT_X        = 380,
  parameter int unsigned INIT_Y        = 280,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_flag1,
  input  logic       key_flag2,
  input  logic       frame_start,
  output logic [9:0] blk_x,
  output logic [9:0] blk_y,
  output logic       moving,
  output logic       fifo_full,
  output logic [7:0] drop_cnt
);

  import vga_game_pkg::*;

  localparam int unsigned REM_W = $clog2(STEP + 1);
  localparam int unsigned X_MAX = H_ACTIVE - BLK_W;
  localparam int unsigned Y_MAX = V_ACTIVE - BLK_H;
`ifdef MOVE_SCHED_CLAMP_EN
  localparam logic [9:0] X_OVF = 10'(X_MAX);
  localparam logic [9:0] Y_OVF = 10'(Y_MAX);
`else
  localparam logic [9:0] X_OVF = '0;
  localparam logic [9:0] Y_OVF = '0;
`endif

  sched_state_t     state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             moving_q, moving_d;
  logic [7:0]       drop_q, drop_d;
  logic [10:0]      nx, ny;
  logic             push, pop;
  dir_t             fifo_dout;
  logic             fifo_is_full, fifo_is_empty;

  assign push = key_flag1 || key_flag2;

  cmd_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({key_flag2, key_flag1}),
    .pop   (pop),
    .rdata (fifo_dout),
    .full  (fifo_is_full),
    .empty (fifo_is_empty)
  );

  // Scheduler next-state, position stepping and drop accounting.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    x_d     = x_q;
    y_d     = y_q;
    drop_d  = drop_q;
    pop     = 1'b0;
    // 11-bit sums so a step past 1023 cannot alias back into range.
    nx      = {1'b0, x_q} + 11'(PIX_PER_FRAME);
    ny      = {1'b0, y_q} + 11'(PIX_PER_FRAME);

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_is_empty) begin
          pop     = 1'b1;
          dir_d   = fifo_dout;
          rem_d   = REM_W'(STEP);
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (frame_start) state_d = S_STEP;
      end
      S_STEP: begin
        if (dir_q[0]) x_d = (nx > 11'(X_MAX)) ? X_OVF : nx[9:0];
        if (dir_q[1]) y_d = (ny > 11'(Y_MAX)) ? Y_OVF : ny[9:0];
        rem_d   = rem_q - REM_W'(PIX_PER_FRAME);
        state_d = (rem_q == REM_W'(PIX_PER_FRAME)) ? S_IDLE : S_WAIT_FRAME;
      end
      default: state_d = S_IDLE;
    endcase

    if (push && fifo_is_full && !pop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    moving_d = (state_d != S_IDLE);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dir_q    <= '0;
      rem_q    <= '0;
      x_q      <= 10'(INIT_X);
      y_q      <= 10'(INIT_Y);
      moving_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      x_q      <= x_d;
      y_q      <= y_d;
      moving_q <= moving_d;
      drop_q   <= drop_d;
    end
  end

  assign blk_x     = x_q;
  assign blk_y     = y_q;
  assign moving    = moving_q;
  assign fifo_full = fifo_is_full;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_move_cmd_sched.sv
// Directed testbench for move_cmd_sched: single, diagonal, overflow,
// reset-mid-move and screen-edge (wrap or clamp) scenarios.
module tb_move_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       k1 = 1'b0, k2 = 1'b0, kw = 1'b0, fs = 1'b0;
  logic [9:0] bx, by, wx, wy;
  logic       mv, ff, wmv, wff;
  logic [7:0] dc, wdc;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  move_cmd_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_flag1   (k1),
    .key_flag2   (k2),
    .frame_start (fs),
    .blk_x       (bx),
    .blk_y       (by),
    .moving      (mv),
    .fifo_full   (ff),
    .drop_cnt    (dc)
  );

  move_cmd_sched #(
    .INIT_X (740)
  ) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_flag1   (kw),
    .key_flag2   (1'b0),
    .frame_start (fs),
    .blk_x       (wx),
    .blk_y       (wy),
    .moving      (wmv),
    .fifo_full   (wff),
    .drop_cnt    (wdc)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame_start pulse in the middle of a 100-cycle window.
  task automatic frame();
    repeat (50) tick();
    fs = 1'b1;
    tick();
    fs = 1'b0;
    repeat (49) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int edge_x [10];

  initial begin
    // Reset state
    do_reset();
    check("rst_x", bx, 380);
    check("rst_y", by, 280);
    check("rst_moving", mv, 0);
    check("rst_full", ff, 0);
    check("rst_drop", dc, 0);
    check("rst_wx", wx, 740);

    // Single +x command
    k1 = 1'b1; tick(); k1 = 1'b0;
    check("single_mv_push", mv, 0);
    tick();
    check("single_mv_load", mv, 1);
    for (int i = 0; i < 10; i++) begin
      frame();
      check($sformatf("single_x%0d", i), bx, 380 + 4 * (i + 1));
      check($sformatf("single_y%0d", i), by, 280);
      check($sformatf("single_mv%0d", i), mv, (i == 9) ? 0 : 1);
    end

    // Diagonal command: one entry, both axes
    do_reset();
    k1 = 1'b1; k2 = 1'b1; tick(); k1 = 1'b0; k2 = 1'b0;
    repeat (10) frame();
    check("diag_x", bx, 420);
    check("diag_y", by, 320);
    check("diag_mv", mv, 0);
    repeat (2) frame();
    check("diag_x_after", bx, 420);
    check("diag_y_after", by, 320);

    // Overflow: 6 back-to-back pushes, first one popped into LOAD
    do_reset();
    k1 = 1'b1; repeat (6) tick(); k1 = 1'b0;
    check("ovf_full", ff, 1);
    check("ovf_drop", dc, 1);
    repeat (50) frame();
    check("ovf_x", bx, 580);
    check("ovf_full_after", ff, 0);
    check("ovf_mv_after", mv, 0);
    check("ovf_drop_after", dc, 1);

    // Reset in the middle of a command with two more queued
    do_reset();
    k1 = 1'b1; repeat (3) tick(); k1 = 1'b0;
    repeat (3) frame();
    check("mid_x_before", bx, 392);
    check("mid_mv_before", mv, 1);
    rst_n = 1'b0;
    #1;
    check("mid_x_rst", bx, 380);
    check("mid_mv_rst", mv, 0);
    check("mid_full_rst", ff, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) frame();
    check("mid_x_after", bx, 380);
    check("mid_mv_after", mv, 0);

    // Screen edge on the INIT_X=740 instance
`ifdef MOVE_SCHED_CLAMP_EN
    edge_x = '{744, 748, 752, 756, 760, 760, 760, 760, 760, 760};
`else
    edge_x = '{744, 748, 752, 756, 760, 0, 4, 8, 12, 16};
`endif
    do_reset();
    kw = 1'b1; tick(); kw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      frame();
      check($sformatf("edge_x%0d", i), wx, edge_x[i]);
    end
    check("edge_y", wy, 280);
    check("edge_mv", wmv, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
